// File: rtl/mls_pkg.sv
// Shared definitions for the 8-bit MLS generator/checker pair.
// Tap set x8+x6+x5+x4, serial output taken from stage 8.
package mls_pkg;

    localparam int MLS_LEN = 8;

    // Tap positions shared with the generator
    localparam int TAP_A = 8;
    localparam int TAP_B = 6;
    localparam int TAP_C = 5;
    localparam int TAP_D = 4;

    typedef enum logic [1:0] {
        SEED,
        VERIFY,
        LOCKED
    } state_t;

    // Next sequence bit from the history window (h[1] is newest)
    function automatic logic mls_predict(input logic [MLS_LEN:1] h);
        return h[TAP_A] ^ h[TAP_B] ^ h[TAP_C] ^ h[TAP_D];
    endfunction

endpackage

// File: rtl/mls_if.sv
// Serial bit stream in, lock/error status out.
// master drives the stream, slave is the checker.
interface mls_if #(
    parameter int CNT_W = 16
);

    logic             din;
    logic             din_en;
    logic             err_clr;
    logic             locked;
    logic             bit_err;
    logic [CNT_W-1:0] err_count;

    modport master (
        output din,
        output din_en,
        output err_clr,
        input  locked,
        input  bit_err,
        input  err_count
    );

    modport slave (
        input  din,
        input  din_en,
        input  err_clr,
        output locked,
        output bit_err,
        output err_count
    );

endinterface

// File: rtl/mls_err_counter.sv
// Saturating error counter with synchronous clear.
// A clear coinciding with an increment leaves the count at one.
module mls_err_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count
);

    // Clear wins over counting, but the coincident error is kept
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clr) begin
            count <= {{(W-1){1'b0}}, inc};
        end else if (inc && (count != {W{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/mls_checker.sv
// Self-synchronising MLS receiver: seeds history from the line,
// verifies predictions, then flywheels and counts bit errors.
module mls_checker
    import mls_pkg::*;
#(
    parameter int LOCK_COUNT = 16,
    parameter int LOSS_COUNT = 4,
    parameter int CNT_W      = 16
) (
    input  logic  clk,
    input  logic  reset,
    mls_if.slave  bus
);

    localparam logic [7:0] LOCK_V = 8'(LOCK_COUNT);
    localparam logic [3:0] LOSS_V = 4'(LOSS_COUNT);
    localparam logic [3:0] RUN_V  = 4'd8;

    state_t             state;
    state_t             state_nxt;
    logic [MLS_LEN:1]   h;
    logic [MLS_LEN:1]   h_nxt;
    logic [MLS_LEN:1]   h_din;
    logic [MLS_LEN:1]   h_pred;
    logic [2:0]         seed_cnt;
    logic [2:0]         seed_nxt;
    logic [7:0]         match_cnt;
    logic [7:0]         match_nxt;
    logic [3:0]         miss_cnt;
    logic [3:0]         miss_nxt;
    logic [3:0]         run_cnt;
    logic [3:0]         run_nxt;
    logic               pred;
    logic               miss;
    logic               err_inc;
    logic               locked_q;
    logic               bit_err_q;
    logic [CNT_W-1:0]   err_count;

    assign pred   = mls_predict(h);
    assign miss   = bus.din ^ pred;
    assign h_din  = {h[MLS_LEN-1:1], bus.din};
    assign h_pred = {h[MLS_LEN-1:1], pred};

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= SEED;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decision, only on enabled bits
    always_comb begin
        state_nxt = state;
        if (bus.din_en) begin
            unique case (state)
                SEED: begin
                    if (seed_cnt == 3'd7) begin
                        state_nxt = VERIFY;
                    end
                end
                VERIFY: begin
                    if (h_din == '0) begin
                        state_nxt = SEED;
                    end else if (!miss &&
                                 (match_cnt + 8'd1 == LOCK_V)) begin
                        state_nxt = LOCKED;
                    end
                end
                LOCKED: begin
                    if (miss && (miss_cnt + 4'd1 == LOSS_V)) begin
                        state_nxt = SEED;
                    end
                end
                default: state_nxt = SEED;
            endcase
        end
    end

    // History shift and counter updates for the current state
    always_comb begin
        h_nxt     = h;
        seed_nxt  = seed_cnt;
        match_nxt = match_cnt;
        miss_nxt  = miss_cnt;
        run_nxt   = run_cnt;
        err_inc   = 1'b0;
        if (bus.din_en) begin
            unique case (state)
                SEED: begin
                    h_nxt     = h_din;
                    seed_nxt  = seed_cnt + 3'd1;
                    match_nxt = '0;
                end
                VERIFY: begin
                    h_nxt     = h_din;
                    seed_nxt  = '0;
                    miss_nxt  = '0;
                    run_nxt   = '0;
                    match_nxt = miss ? 8'd0 : match_cnt + 8'd1;
                end
                LOCKED: begin
                    // Flywheel: the predicted bit keeps history clean
                    h_nxt = h_pred;
                    if (miss) begin
                        err_inc  = 1'b1;
                        miss_nxt = miss_cnt + 4'd1;
                        run_nxt  = '0;
                    end else if (run_cnt + 4'd1 == RUN_V) begin
                        miss_nxt = '0;
                        run_nxt  = '0;
                    end else begin
                        run_nxt = run_cnt + 4'd1;
                    end
                    if (state_nxt == SEED) begin
                        seed_nxt = '0;
                        miss_nxt = '0;
                        run_nxt  = '0;
                    end
                end
                default: begin
                    seed_nxt = '0;
                end
            endcase
        end
    end

    // History and counter registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            h         <= '0;
            seed_cnt  <= '0;
            match_cnt <= '0;
            miss_cnt  <= '0;
            run_cnt   <= '0;
        end else begin
            h         <= h_nxt;
            seed_cnt  <= seed_nxt;
            match_cnt <= match_nxt;
            miss_cnt  <= miss_nxt;
            run_cnt   <= run_nxt;
        end
    end

    // Status outputs land on the same edge as the sampled bit
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            locked_q  <= 1'b0;
            bit_err_q <= 1'b0;
        end else begin
            locked_q  <= (state_nxt == LOCKED);
            bit_err_q <= err_inc;
        end
    end

    mls_err_counter #(
        .W (CNT_W)
    ) u_err_counter (
        .clk   (clk),
        .reset (reset),
        .clr   (bus.err_clr),
        .inc   (err_inc),
        .count (err_count)
    );

    assign bus.locked    = locked_q;
    assign bus.bit_err   = bit_err_q;
    assign bus.err_count = err_count;

endmodule

// File: tb/tb_mls_checker.sv
// Bench for mls_checker: scripted lock/error/loss sequences
// plus random traffic against a rule-level reference model.
module tb_mls_checker;

    localparam int LOCK_N = 16;
    localparam int LOSS_N = 4;
    localparam int CW     = 4;
    localparam int MAXC   = (1 << CW) - 1;

    logic clk = 1'b0;
    logic reset;

    mls_if #(.CNT_W(CW)) bus();

    mls_checker #(
        .LOCK_COUNT (LOCK_N),
        .LOSS_COUNT (LOSS_N),
        .CNT_W      (CW)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    bit sbits[0:8191];

    typedef struct {
        int bitno;
        bit inv;
        bit clr;
        bit exp_lock;
        bit exp_berr;
        int exp_cnt;
    } vec_t;

    vec_t tbl[$];

    // Reference model state
    int m_mode;
    int m_seed;
    int m_match;
    int m_miss;
    int m_run;
    int m_err;
    bit m_berr;
    bit m_locked;
    bit m_hist[$];

    task automatic check(input string name,
                         input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d required %0d", name, act, exp);
        end
    endtask

    function automatic void model_reset();
        m_mode = 0; m_seed = 0; m_match = 0;
        m_miss = 0; m_run = 0; m_err = 0;
        m_berr = 0; m_locked = 0;
        m_hist.delete();
        for (int i = 0; i < 8; i++) m_hist.push_back(1'b0);
    endfunction

    function automatic void model_push(bit b);
        m_hist.push_front(b);
        void'(m_hist.pop_back());
    endfunction

    function automatic void model_step(bit d, bit en, bit clr);
        bit p;
        bit mis;
        bit inc;
        int ones;
        inc = 0;
        m_berr = 0;
        if (en) begin
            p = m_hist[7] ^ m_hist[5] ^ m_hist[4] ^ m_hist[3];
            mis = (d != p);
            if (m_mode == 0) begin
                model_push(d);
                m_seed++;
                if (m_seed == 8) begin
                    m_mode = 1; m_seed = 0; m_match = 0;
                end
            end else if (m_mode == 1) begin
                model_push(d);
                m_match = mis ? 0 : m_match + 1;
                ones = 0;
                foreach (m_hist[i]) ones += int'(m_hist[i]);
                if (ones == 0) begin
                    m_mode = 0; m_seed = 0;
                end else if (m_match == LOCK_N) begin
                    m_mode = 2; m_miss = 0; m_run = 0;
                end
            end else begin
                model_push(p);
                if (mis) begin
                    inc = 1; m_berr = 1;
                    m_miss++; m_run = 0;
                    if (m_miss == LOSS_N) begin
                        m_mode = 0; m_seed = 0; m_miss = 0;
                    end
                end else begin
                    m_run++;
                    if (m_run == 8) begin
                        m_run = 0; m_miss = 0;
                    end
                end
            end
        end
        if (clr) m_err = int'(inc);
        else if (inc && m_err < MAXC) m_err++;
        m_locked = (m_mode == 2);
    endfunction

    task automatic step(input logic d, input logic en, input logic clr);
        bus.din     = d;
        bus.din_en  = en;
        bus.err_clr = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        bus.din = 0; bus.din_en = 0; bus.err_clr = 0;
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("rst_locked", bus.locked, 0);
        check("rst_bit_err", bus.bit_err, 0);
        check("rst_err_count", bus.err_count, 0);
        #3;
        reset = 1'b0;
        model_reset();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int ti;
        int pulses;
        int drops;
        int lk;
        int idx;
        int rates[5];
        bit inv;
        bit en;
        bit clr;
        bit d;
        reset = 1'b1;
        bus.din = 0; bus.din_en = 0; bus.err_clr = 0;

        for (int n = 0; n < 8192; n++) begin
            if (n < 8) sbits[n] = 1'b1;
            else sbits[n] = sbits[n-8] ^ sbits[n-6] ^
                            sbits[n-5] ^ sbits[n-4];
        end

        // Clean lock, single errors, clear collision, loss/relock
        tbl.push_back('{23,  0, 0, 0, 0, 0});
        tbl.push_back('{24,  0, 0, 1, 0, 0});
        tbl.push_back('{100, 0, 0, 1, 0, 0});
        tbl.push_back('{200, 1, 0, 1, 1, 1});
        tbl.push_back('{201, 0, 0, 1, 0, 1});
        tbl.push_back('{300, 1, 1, 1, 1, 1});
        tbl.push_back('{301, 0, 0, 1, 0, 1});
        tbl.push_back('{400, 1, 0, 1, 1, 2});
        tbl.push_back('{401, 0, 0, 1, 0, 2});
        tbl.push_back('{402, 1, 0, 1, 1, 3});
        tbl.push_back('{404, 1, 0, 1, 1, 4});
        tbl.push_back('{405, 0, 0, 1, 0, 4});
        tbl.push_back('{406, 1, 0, 0, 1, 5});
        tbl.push_back('{407, 0, 0, 0, 0, 5});
        tbl.push_back('{429, 0, 0, 0, 0, 5});
        tbl.push_back('{430, 0, 0, 1, 0, 5});
        tbl.push_back('{1000, 0, 0, 1, 0, 5});

        do_reset();
        ti = 0; pulses = 0; drops = 0;
        for (int k = 1; k <= 1000; k++) begin
            inv = 0; clr = 0;
            if (ti < tbl.size() && tbl[ti].bitno == k) begin
                inv = tbl[ti].inv;
                clr = tbl[ti].clr;
            end
            step(sbits[k-1] ^ inv, 1'b1, clr);
            pulses += int'(bus.bit_err);
            if (((k >= 24 && k < 406) || k >= 430) && !bus.locked)
                drops++;
            if (ti < tbl.size() && tbl[ti].bitno == k) begin
                check($sformatf("tbl%0d_locked", k),
                      bus.locked, tbl[ti].exp_lock);
                check($sformatf("tbl%0d_bit_err", k),
                      bus.bit_err, tbl[ti].exp_berr);
                check($sformatf("tbl%0d_err_count", k),
                      bus.err_count, tbl[ti].exp_cnt);
                ti++;
            end
        end
        check("clean_bit_err_pulses", pulses, 6);
        check("clean_lock_drops", drops, 0);

        // Stuck-at lines never lock
        for (int v = 0; v < 2; v++) begin
            do_reset();
            lk = 0;
            repeat (2000) begin
                step(v[0], 1'b1, 1'b0);
                lk += int'(bus.locked);
            end
            check($sformatf("stuck%0d_lock_cycles", v), lk, 0);
            check($sformatf("stuck%0d_err_count", v), bus.err_count, 0);
        end

        // Gapped enable: lock on the 24th enabled bit at edge 47
        do_reset();
        idx = 0; pulses = 0;
        for (int e = 1; e <= 48; e++) begin
            en = (e % 2 == 1);
            d = en ? sbits[idx] : 1'($urandom_range(0, 1));
            if (en) idx++;
            step(d, en, 1'b0);
            pulses += int'(bus.bit_err);
            if (e == 46) check("gap_e46_locked", bus.locked, 0);
            if (e == 47) check("gap_e47_locked", bus.locked, 1);
            if (e == 48) check("gap_e48_locked", bus.locked, 1);
        end
        check("gap_bit_err_pulses", pulses, 0);

        // Asynchronous reset while locked with five errors counted
        do_reset();
        for (int k = 1; k <= 80; k++) begin
            inv = (k == 40 || k == 50 || k == 60 || k == 70 || k == 80);
            step(sbits[k-1] ^ inv, 1'b1, 1'b0);
        end
        check("pre_arst_locked", bus.locked, 1);
        check("pre_arst_bit_err", bus.bit_err, 1);
        check("pre_arst_err_count", bus.err_count, 5);
        #2;
        reset = 1'b1;
        #1;
        check("arst_locked", bus.locked, 0);
        check("arst_bit_err", bus.bit_err, 0);
        check("arst_err_count", bus.err_count, 0);
        #1;
        reset = 1'b0;
        for (int k = 81; k <= 104; k++) begin
            step(sbits[k-1], 1'b1, 1'b0);
            if (k == 103) check("arst_relock_103", bus.locked, 0);
            if (k == 104) check("arst_relock_104", bus.locked, 1);
        end

        // Random traffic against the reference model
        do_reset();
        rates[0] = 0; rates[1] = 3; rates[2] = 8;
        rates[3] = 25; rates[4] = 1;
        idx = 500;
        for (int s = 0; s < 5; s++) begin
            for (int c = 0; c < 500; c++) begin
                en  = ($urandom_range(0, 3) != 0);
                inv = ($urandom_range(0, 99) < rates[s]);
                clr = ($urandom_range(0, 399) == 0);
                d = en ? (sbits[idx] ^ inv) : 1'($urandom_range(0, 1));
                if (en) idx++;
                model_step(d, en, clr);
                step(d, en, clr);
                check("rnd_locked", bus.locked, 32'(m_locked));
                check("rnd_bit_err", bus.bit_err, 32'(m_berr));
                check("rnd_err_count", bus.err_count, m_err);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
